// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage of the 16-bit MIPS pipeline: decode, WB bypass, load-use stall, ID/EX register.
module decode_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [PC_W-1:0]   if_pc,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall,
  output logic [ADDR_W-1:0] rf_addr_1,
  output logic [ADDR_W-1:0] rf_addr_2,
  input  logic [DATA_W-1:0] rf_data_1,
  input  logic [DATA_W-1:0] rf_data_2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_valid,
  output logic [PC_W-1:0]   id_pc,
  output logic [DATA_W-1:0] id_op1,
  output logic [DATA_W-1:0] id_op2,
  output logic [DATA_W-1:0] id_imm,
  output logic [ADDR_W-1:0] id_dest,
  output logic [2:0]        id_alu_op,
  output logic              id_alu_src,
  output logic              id_mem_rd,
  output logic              id_mem_wr,
  output logic              id_reg_wr,
  output logic              id_branch,
  output logic              id_illegal
);

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;

  logic [3:0]        op;
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [2:0]        funct;
  logic [DATA_W-1:0] imm_ext;

  assign op      = if_instr[15:12];
  assign rs      = if_instr[11:9];
  assign rt      = if_instr[8:6];
  assign rd      = if_instr[5:3];
  assign funct   = if_instr[2:0];
  assign imm_ext = {{(DATA_W-6){if_instr[5]}}, if_instr[5:0]};

  assign rf_addr_1 = rs;
  assign rf_addr_2 = rt;

  logic [ADDR_W-1:0] dec_dest;
  logic [2:0]        dec_alu_op;
  logic              dec_alu_src, dec_mem_rd, dec_mem_wr, dec_reg_wr_raw, dec_reg_wr;
  logic              dec_branch, dec_illegal, uses_rs, uses_rt;

  always_comb begin
    dec_dest       = '0;
    dec_alu_op     = 3'b000;
    dec_alu_src    = 1'b0;
    dec_mem_rd     = 1'b0;
    dec_mem_wr     = 1'b0;
    dec_reg_wr_raw = 1'b0;
    dec_branch     = 1'b0;
    dec_illegal    = 1'b0;
    uses_rs        = 1'b0;
    uses_rt        = 1'b0;
    case (op)
      OP_R: begin
        dec_dest = rd; dec_alu_op = funct; dec_reg_wr_raw = 1'b1;
        uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_ADDI: begin
        dec_dest = rt; dec_alu_src = 1'b1; dec_reg_wr_raw = 1'b1; uses_rs = 1'b1;
      end
      OP_LW: begin
        dec_dest = rt; dec_alu_src = 1'b1; dec_mem_rd = 1'b1; dec_reg_wr_raw = 1'b1;
        uses_rs = 1'b1;
      end
      OP_SW: begin
        dec_alu_src = 1'b1; dec_mem_wr = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_BEQ: begin
        dec_alu_op = 3'b001; dec_branch = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    dec_reg_wr = dec_reg_wr_raw & (dec_dest != '0);
  end

  // The register file returns stale data during its own write cycle, so snoop the write port.
  logic [DATA_W-1:0] op1_byp, op2_byp;
  assign op1_byp = (rs == '0) ? '0 : (wb_en && wb_dest == rs) ? wb_data : rf_data_1;
  assign op2_byp = (rt == '0) ? '0 : (wb_en && wb_dest == rt) ? wb_data : rf_data_2;

  logic              id_valid_q, id_valid_d;
  logic [PC_W-1:0]   id_pc_q, id_pc_d;
  logic [DATA_W-1:0] id_op1_q, id_op1_d, id_op2_q, id_op2_d, id_imm_q, id_imm_d;
  logic [ADDR_W-1:0] id_dest_q, id_dest_d;
  logic [2:0]        id_alu_op_q, id_alu_op_d;
  logic              id_alu_src_q, id_alu_src_d, id_mem_rd_q, id_mem_rd_d;
  logic              id_mem_wr_q, id_mem_wr_d, id_reg_wr_q, id_reg_wr_d;
  logic              id_branch_q, id_branch_d, id_illegal_q, id_illegal_d;

  logic load_use;
  assign load_use = id_valid_q & id_mem_rd_q & (id_dest_q != '0) & if_valid &
                    ((uses_rs & (rs == id_dest_q)) | (uses_rt & (rt == id_dest_q)));
  assign stall = rst_n & (ex_hold | load_use) & ~flush;

  always_comb begin
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_op1_d     = id_op1_q;
    id_op2_d     = id_op2_q;
    id_imm_d     = id_imm_q;
    id_dest_d    = id_dest_q;
    id_alu_op_d  = id_alu_op_q;
    id_alu_src_d = id_alu_src_q;
    id_mem_rd_d  = id_mem_rd_q;
    id_mem_wr_d  = id_mem_wr_q;
    id_reg_wr_d  = id_reg_wr_q;
    id_branch_d  = id_branch_q;
    id_illegal_d = id_illegal_q;
    if (flush || (!ex_hold && load_use)) begin
      // Bubble: data fields keep their old contents, only validity and control are cleared.
      id_valid_d   = 1'b0;
      id_alu_op_d  = 3'b000;
      id_alu_src_d = 1'b0;
      id_mem_rd_d  = 1'b0;
      id_mem_wr_d  = 1'b0;
      id_reg_wr_d  = 1'b0;
      id_branch_d  = 1'b0;
      id_illegal_d = 1'b0;
    end else if (!ex_hold) begin
      id_valid_d   = if_valid;
      id_pc_d      = if_pc;
      id_op1_d     = op1_byp;
      id_op2_d     = op2_byp;
      id_imm_d     = imm_ext;
      id_dest_d    = dec_dest;
      id_alu_op_d  = if_valid ? dec_alu_op : 3'b000;
      id_alu_src_d = dec_alu_src & if_valid;
      id_mem_rd_d  = dec_mem_rd & if_valid;
      id_mem_wr_d  = dec_mem_wr & if_valid;
      id_reg_wr_d  = dec_reg_wr & if_valid;
      id_branch_d  = dec_branch & if_valid;
      id_illegal_d = dec_illegal & if_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_op1_q     <= '0;
      id_op2_q     <= '0;
      id_imm_q     <= '0;
      id_dest_q    <= '0;
      id_alu_op_q  <= 3'b000;
      id_alu_src_q <= 1'b0;
      id_mem_rd_q  <= 1'b0;
      id_mem_wr_q  <= 1'b0;
      id_reg_wr_q  <= 1'b0;
      id_branch_q  <= 1'b0;
      id_illegal_q <= 1'b0;
    end else begin
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_op1_q     <= id_op1_d;
      id_op2_q     <= id_op2_d;
      id_imm_q     <= id_imm_d;
      id_dest_q    <= id_dest_d;
      id_alu_op_q  <= id_alu_op_d;
      id_alu_src_q <= id_alu_src_d;
      id_mem_rd_q  <= id_mem_rd_d;
      id_mem_wr_q  <= id_mem_wr_d;
      id_reg_wr_q  <= id_reg_wr_d;
      id_branch_q  <= id_branch_d;
      id_illegal_q <= id_illegal_d;
    end
  end

  assign id_valid   = id_valid_q;
  assign id_pc      = id_pc_q;
  assign id_op1     = id_op1_q;
  assign id_op2     = id_op2_q;
  assign id_imm     = id_imm_q;
  assign id_dest    = id_dest_q;
  assign id_alu_op  = id_alu_op_q;
  assign id_alu_src = id_alu_src_q;
  assign id_mem_rd  = id_mem_rd_q;
  assign id_mem_wr  = id_mem_wr_q;
  assign id_reg_wr  = id_reg_wr_q;
  assign id_branch  = id_branch_q;
  assign id_illegal = id_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed-vector bench for decode_stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        flush, ex_hold;
  logic        stall;
  logic [2:0]  rf_addr_1, rf_addr_2;
  logic [15:0] rf_data_1, rf_data_2;
  logic        wb_en;
  logic [2:0]  wb_dest;
  logic [15:0] wb_data;
  logic        id_valid;
  logic [15:0] id_pc, id_op1, id_op2, id_imm;
  logic [2:0]  id_dest, id_alu_op;
  logic        id_alu_src, id_mem_rd, id_mem_wr, id_reg_wr, id_branch, id_illegal;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .ex_hold(ex_hold), .stall(stall),
    .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2), .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_op1(id_op1), .id_op2(id_op2), .id_imm(id_imm),
    .id_dest(id_dest), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_reg_wr(id_reg_wr),
    .id_branch(id_branch), .id_illegal(id_illegal)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] r_ins(input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [2:0] rd, input logic [2:0] fn);
    return {4'h0, rs, rt, rd, fn};
  endfunction

  function automatic logic [15:0] i_ins(input logic [3:0] op, input logic [2:0] rs,
                                        input logic [2:0] rt, input logic [5:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    rst_n = 1'b0; if_valid = 1'b1; if_instr = i_ins(4'h1, 3'd0, 3'd1, 6'd5); if_pc = 16'h0010;
    flush = 1'b0; ex_hold = 1'b1; rf_data_1 = '0; rf_data_2 = '0;
    wb_en = 1'b0; wb_dest = '0; wb_data = '0;

    // Reset state, with ex_hold asserted
    tick(); tick();
    check("rst_valid", {15'd0, id_valid}, 16'h0);
    check("rst_imm", id_imm, 16'h0);
    check("rst_dest", {13'd0, id_dest}, 16'h0);
    check("rst_stall", {15'd0, stall}, 16'h0);

    // Release away from the edge, issue ADDI r1,r0,5
    rst_n = 1'b1; ex_hold = 1'b0;
    tick();
    check("addi_valid", {15'd0, id_valid}, 16'h1);
    check("addi_imm", id_imm, 16'h0005);
    check("addi_dest", {13'd0, id_dest}, 16'h1);
    check("addi_regwr", {15'd0, id_reg_wr}, 16'h1);
    check("addi_src", {15'd0, id_alu_src}, 16'h1);
    check("addi_pc", id_pc, 16'h0010);

    // Async reset mid-stall
    ex_hold = 1'b1; #1;
    check("hold_stall", {15'd0, stall}, 16'h1);
    rst_n = 1'b0; #1;
    check("async_valid", {15'd0, id_valid}, 16'h0);
    check("async_imm", id_imm, 16'h0);
    check("async_regwr", {15'd0, id_reg_wr}, 16'h0);
    check("async_stall", {15'd0, stall}, 16'h0);
    tick();
    rst_n = 1'b1; ex_hold = 1'b0;
    tick();
    check("rel_imm", id_imm, 16'h0005);
    check("rel_dest", {13'd0, id_dest}, 16'h1);
    check("rel_regwr", {15'd0, id_reg_wr}, 16'h1);

    // WB bypass: add r3,r2,r2
    if_instr = r_ins(3'd2, 3'd2, 3'd3, 3'd0); rf_data_1 = 16'h0000; rf_data_2 = 16'h0000;
    wb_en = 1'b1; wb_dest = 3'd2; wb_data = 16'hBEEF; #1;
    check("addr1", {13'd0, rf_addr_1}, 16'h2);
    check("addr2", {13'd0, rf_addr_2}, 16'h2);
    tick();
    check("byp_op1", id_op1, 16'hBEEF);
    check("byp_op2", id_op2, 16'hBEEF);
    check("byp_dest", {13'd0, id_dest}, 16'h3);
    check("byp_alusrc", {15'd0, id_alu_src}, 16'h0);
    // sub-like funct with only rs bypassed
    if_instr = r_ins(3'd2, 3'd6, 3'd7, 3'd2); rf_data_2 = 16'h2222;
    tick();
    check("mix_op1", id_op1, 16'hBEEF);
    check("mix_op2", id_op2, 16'h2222);
    check("mix_aluop", {13'd0, id_alu_op}, 16'h2);

    // Load-use: LW r4,2(r1) then add r5,r4,r1
    wb_en = 1'b0; rf_data_1 = 16'h1111; rf_data_2 = 16'h3333;
    if_instr = i_ins(4'h2, 3'd1, 3'd4, 6'd2);
    tick();
    check("lw_memrd", {15'd0, id_mem_rd}, 16'h1);
    check("lw_dest", {13'd0, id_dest}, 16'h4);
    if_instr = r_ins(3'd4, 3'd1, 3'd5, 3'd0); #1;
    check("lu_stall", {15'd0, stall}, 16'h1);
    tick();
    check("lu_bubble", {15'd0, id_valid}, 16'h0);
    check("lu_stall_off", {15'd0, stall}, 16'h0);
    tick();
    check("lu_issue", {15'd0, id_valid}, 16'h1);
    check("lu_dest", {13'd0, id_dest}, 16'h5);
    check("lu_regwr", {15'd0, id_reg_wr}, 16'h1);
    check("lu_memrd", {15'd0, id_mem_rd}, 16'h0);
    // LW to r0 never creates a hazard
    if_instr = i_ins(4'h2, 3'd1, 3'd0, 6'd0);
    tick();
    check("lw0_regwr", {15'd0, id_reg_wr}, 16'h0);
    if_instr = r_ins(3'd0, 3'd0, 3'd5, 3'd0); #1;
    check("lw0_nostall", {15'd0, stall}, 16'h0);
    tick();

    // r0 rules
    rf_data_1 = 16'h5555; rf_data_2 = 16'h7777; wb_en = 1'b1; wb_dest = 3'd0; wb_data = 16'h1234;
    if_instr = r_ins(3'd0, 3'd1, 3'd2, 3'd0);
    tick();
    check("r0_op1", id_op1, 16'h0000);
    check("r0_op2", id_op2, 16'h7777);
    wb_en = 1'b0;
    if_instr = i_ins(4'h1, 3'd1, 3'd0, 6'h3F);
    tick();
    check("r0_regwr", {15'd0, id_reg_wr}, 16'h0);
    check("r0_imm", id_imm, 16'hFFFF);
    check("r0_valid", {15'd0, id_valid}, 16'h1);

    // Hold, then flush during hold
    if_instr = i_ins(4'h1, 3'd0, 3'd6, 6'd7);
    tick();
    ex_hold = 1'b1; if_instr = i_ins(4'h4, 3'd1, 3'd2, 6'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_stall_n", {15'd0, stall}, 16'h1);
      check("hold_imm", id_imm, 16'h0007);
      check("hold_dest", {13'd0, id_dest}, 16'h6);
      check("hold_branch", {15'd0, id_branch}, 16'h0);
    end
    flush = 1'b1; #1;
    check("flush_stall", {15'd0, stall}, 16'h0);
    tick();
    check("flush_valid", {15'd0, id_valid}, 16'h0);
    check("flush_regwr", {15'd0, id_reg_wr}, 16'h0);
    flush = 1'b0; ex_hold = 1'b0;
    tick();
    check("beq_branch", {15'd0, id_branch}, 16'h1);
    check("beq_aluop", {13'd0, id_alu_op}, 16'h1);
    check("beq_regwr", {15'd0, id_reg_wr}, 16'h0);
    if_instr = i_ins(4'h3, 3'd1, 3'd2, 6'd4);
    tick();
    check("sw_memwr", {15'd0, id_mem_wr}, 16'h1);
    check("sw_alusrc", {15'd0, id_alu_src}, 16'h1);
    check("sw_regwr", {15'd0, id_reg_wr}, 16'h0);
    if_instr = 16'hE000;
    tick();
    check("ill_flag", {15'd0, id_illegal}, 16'h1);
    check("ill_valid", {15'd0, id_valid}, 16'h1);
    check("ill_ctrl", {12'd0, id_reg_wr, id_mem_rd, id_mem_wr, id_branch}, 16'h0);
    if_valid = 1'b0;
    tick();
    check("nv_valid", {15'd0, id_valid}, 16'h0);
    check("nv_illegal", {15'd0, id_illegal}, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
